// File: rtl/route_ring_array_if.sv
// Control/observation bundle for route_ring_array: load port, run/mode controls and ring taps.
// master = routing harness, slave = the ring array.
interface route_ring_array_if #(
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 8,
  parameter int CNT_W    = 16
);
  logic [1:0]                mode;
  logic                      load_valid;
  logic                      load_ready;
  logic [CHANNELS*DEPTH-1:0] load_data;
  logic                      run;
  logic [CHANNELS-1:0]       q;
  logic [CNT_W-1:0]          cycle_cnt;
  logic                      wrap;
  logic                      busy;

  modport master (
    output mode, load_valid, load_data, run,
    input  load_ready, q, cycle_cnt, wrap, busy
  );

  modport slave (
    input  mode, load_valid, load_data, run,
    output load_ready, q, cycle_cnt, wrap, busy
  );
endinterface

// File: rtl/route_ring_array.sv
// CHANNELS independent DEPTH-stage register rings (hold/toggle/rotate/LFSR) for routing bring-up.
// Optional ROUTE_RING_PARITY_EN adds a registered per-ring parity output.
module route_ring_array #(
  parameter int                 CHANNELS = 4,
  parameter int                 DEPTH    = 8,
  parameter int                 CNT_W    = 16,
  parameter logic [DEPTH-1:0]   SEED     = 8'h01,
  parameter logic [DEPTH-1:0]   TAPS     = 8'hB8
) (
  input  logic                  clk,
  input  logic                  rst,
  route_ring_array_if.slave     bus
`ifdef ROUTE_RING_PARITY_EN
  ,output logic [CHANNELS-1:0]  parity
`endif
);

  localparam int PH_W = $clog2(DEPTH);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [1:0] MODE_TOGGLE = 2'b01;
  localparam logic [1:0] MODE_ROTATE = 2'b10;
  localparam logic [1:0] MODE_LFSR   = 2'b11;

  logic [0:0]                     state_q, state_d;
  logic [CHANNELS-1:0][DEPTH-1:0] ring_q, ring_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [PH_W-1:0]                phase_q, phase_d;
  logic                           wrap_q, wrap_d;
  logic                           do_load, do_step;
  logic [CHANNELS-1:0]            tap_w;

  // Control path: loads only in IDLE, rings step only on RUN edges with run still high.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    wrap_d  = 1'b0;
    do_load = 1'b0;
    do_step = 1'b0;
    if (state_q == S_IDLE) begin
      if (bus.load_valid) begin
        do_load = 1'b1;
        cnt_d   = '0;
        phase_d = '0;
      end else if (bus.run) begin
        state_d = S_RUN;
      end
    end else begin
      if (!bus.run) begin
        state_d = S_IDLE;
      end else begin
        do_step = 1'b1;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        if (bus.mode == MODE_ROTATE) begin
          phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
          wrap_d  = (phase_q == PH_LAST);
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [DEPTH-1:0] stepped;
      logic             fb;

      // An all-zero LFSR would stay stuck, so force a 1 into stage 0.
      assign fb = (ring_q[gi] == '0) ? 1'b1 : ^(ring_q[gi] & TAPS);

      always_comb begin
        case (bus.mode)
          MODE_TOGGLE: stepped = ~ring_q[gi];
          MODE_ROTATE: stepped = {ring_q[gi][DEPTH-2:0], ring_q[gi][DEPTH-1]};
          MODE_LFSR:   stepped = {ring_q[gi][DEPTH-2:0], fb};
          default:     stepped = ring_q[gi];
        endcase
      end

      assign ring_d[gi] = do_load ? bus.load_data[gi*DEPTH +: DEPTH] :
                          do_step ? stepped : ring_q[gi];
      assign tap_w[gi]  = ring_q[gi][DEPTH-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ring_q  <= {CHANNELS{SEED}};
      cnt_q   <= '0;
      phase_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ring_q  <= ring_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.q          = tap_w;
  assign bus.cycle_cnt  = cnt_q;
  assign bus.wrap       = wrap_q;
  assign bus.busy       = (state_q == S_RUN);
  assign bus.load_ready = (state_q == S_IDLE);

`ifdef ROUTE_RING_PARITY_EN
  logic [CHANNELS-1:0] parity_q, parity_d;

  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_par
      assign parity_d[gi] = ^ring_d[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) parity_q <= '0;
    else     parity_q <= parity_d;
  end

  assign parity = parity_q;
`endif

endmodule

// File: tb/tb_route_ring_array.sv
// Scoreboard bench for route_ring_array: driver pushes model expectations, monitor pops and compares.
module tb_route_ring_array;
  localparam int CH = 4;
  localparam int D  = 8;
  localparam int CW = 4;
  localparam logic [7:0] SEED = 8'h01;
  localparam logic [7:0] TAPS = 8'hB8;

  typedef struct packed {
    logic [CH-1:0] q;
    logic [CW-1:0] cnt;
    logic          wrap;
    logic          busy;
    logic          lr;
    logic [CH-1:0] par;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  route_ring_array_if #(.CHANNELS(CH), .DEPTH(D), .CNT_W(CW)) bus ();

`ifdef ROUTE_RING_PARITY_EN
  logic [CH-1:0] parity;
`endif

  route_ring_array #(
    .CHANNELS(CH), .DEPTH(D), .CNT_W(CW), .SEED(SEED), .TAPS(TAPS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ROUTE_RING_PARITY_EN
    ,.parity(parity)
`endif
  );

  // Reference model: whole rings as bytes, counters as plain integers.
  logic [7:0] m_ring [CH];
  bit         m_running;
  int         m_cnt;
  int         m_phase;
  bit         m_wrap;
  logic [CH-1:0] m_par;

  exp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;
  bit   drive_done = 0;

  function automatic logic [7:0] next_ring(input logic [7:0] s, input logic [1:0] m);
    logic fb;
    case (m)
      2'b01:   return ~s;
      2'b10:   return (s << 1) | (s >> 7);
      2'b11: begin
        fb = (s == 8'h00) ? 1'b1 : logic'($countones(s & TAPS) % 2);
        return {s[6:0], fb};
      end
      default: return s;
    endcase
  endfunction

  task automatic step(input bit r, input logic [1:0] m, input bit lv,
                      input logic [31:0] ld, input bit rn);
    exp_t e;
    @(negedge clk);
    rst            = r;
    bus.mode       = m;
    bus.load_valid = lv;
    bus.load_data  = ld;
    bus.run        = rn;
    m_wrap = 0;
    if (r) begin
      m_running = 0; m_cnt = 0; m_phase = 0;
      for (int c = 0; c < CH; c++) m_ring[c] = SEED;
      m_par = '0;
    end else begin
      if (!m_running) begin
        if (lv) begin
          for (int c = 0; c < CH; c++) m_ring[c] = ld[c*8 +: 8];
          m_cnt = 0; m_phase = 0;
        end else if (rn) m_running = 1;
      end else if (!rn) begin
        m_running = 0;
      end else begin
        for (int c = 0; c < CH; c++) m_ring[c] = next_ring(m_ring[c], m);
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        if (m == 2'b10) begin
          m_phase = (m_phase + 1) % D;
          m_wrap  = (m_phase == 0);
        end
      end
      for (int c = 0; c < CH; c++) m_par[c] = ^m_ring[c];
    end
    for (int c = 0; c < CH; c++) e.q[c] = m_ring[c][7];
    e.cnt  = m_cnt[CW-1:0];
    e.wrap = m_wrap;
    e.busy = m_running;
    e.lr   = !m_running;
    e.par  = m_par;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s txn=%0d got=%0h exp=%0h", name, txn, got, want);
    end
  endtask

  // Monitor: one expectation per clock, sampled 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        check("q",          32'(bus.q),          32'(e.q));
        check("cycle_cnt",  32'(bus.cycle_cnt),  32'(e.cnt));
        check("wrap",       32'(bus.wrap),       32'(e.wrap));
        check("busy",       32'(bus.busy),       32'(e.busy));
        check("load_ready", 32'(bus.load_ready), 32'(e.lr));
`ifdef ROUTE_RING_PARITY_EN
        check("parity",     32'(parity),         32'(e.par));
`endif
        $display("txn %0d q=%h cnt=%0d wrap=%0b busy=%0b ready=%0b",
                 txn, bus.q, bus.cycle_cnt, bus.wrap, bus.busy, bus.load_ready);
      end
    end
  end

  initial begin
    bus.mode = 2'b00; bus.load_valid = 1'b0; bus.load_data = '0; bus.run = 1'b0;
    // Reset for two cycles.
    repeat (2) step(1, 2'b00, 0, 32'h0, 0);
    // Toggle from 0x81.
    step(0, 2'b01, 1, 32'h81818181, 0);
    repeat (4) step(0, 2'b01, 0, 32'h0, 1);
    step(0, 2'b01, 0, 32'h0, 0);
    // Rotate a single one around channel 0 for a full lap plus one.
    step(0, 2'b10, 1, 32'h00000001, 0);
    repeat (10) step(0, 2'b10, 0, 32'h0, 1);
    step(0, 2'b10, 0, 32'h0, 0);
    // LFSR lock-up escape from all zeros.
    step(0, 2'b11, 1, 32'h00000000, 0);
    repeat (4) step(0, 2'b11, 0, 32'h0, 1);
    step(0, 2'b11, 0, 32'h0, 0);
    // Hold long enough to saturate the counter.
    step(0, 2'b00, 1, 32'hA5C3_5A81, 0);
    repeat (21) step(0, 2'b00, 0, 32'h0, 1);
    step(0, 2'b00, 0, 32'h0, 0);
    // Load beats run in IDLE; load_valid ignored during RUN.
    step(0, 2'b10, 1, 32'h8040_2010, 1);
    step(0, 2'b10, 0, 32'h0, 1);
    repeat (3) step(0, 2'b10, 1, 32'hFFFF_FFFF, 1);
    step(0, 2'b10, 0, 32'h0, 0);
    // Mid-run reset.
    step(0, 2'b01, 0, 32'h0, 1);
    step(0, 2'b01, 0, 32'h0, 1);
    step(1, 2'b01, 0, 32'h0, 1);
    // Randomised traffic.
    for (int i = 0; i < 300; i++)
      step(($urandom % 97) == 0, 2'($urandom_range(0, 3)), ($urandom % 6) == 0,
           $urandom, ($urandom % 8) != 0);
    drive_done = 1;
  end

  initial begin
    wait (drive_done);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=hung exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/route_ring_array.md
Name: route_ring_array

Overview:
Parametrised successor of the single-slice Q→A feedback routing test register. It provides CHANNELS independent DEPTH-stage register rings. Each ring runs in hold, toggle, rotate or LFSR mode, so routed register-to-register paths are exercised at configurable width and depth. A valid/ready load port, a cycle counter and a rotate wrap detector let the routing fuzz/bring-up harness check ring integrity after placement.

Parameters:
CHANNELS, 4, number of independent rings
DEPTH, 8, stages per ring (>=2)
CNT_W, 16, width of the saturating run-cycle counter
SEED, 8'h01, DEPTH-bit reset pattern loaded into every ring
TAPS, 8'hB8, DEPTH-bit LFSR tap mask

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous, active-high reset
mode  in  2  00 hold, 01 toggle, 10 rotate, 11 LFSR
load_valid  in  1  load request
load_ready  out  1  high only in IDLE
load_data  in  CHANNELS*DEPTH  ring c = bits [c*DEPTH +: DEPTH]; bit DEPTH-1 is the tap
run  in  1  level: run rings while high
q  out  CHANNELS  registered tap (stage DEPTH-1) of each ring
cycle_cnt  out  CNT_W  RUN cycles since last load, saturating
wrap  out  1  one-cycle pulse when a rotate completes DEPTH steps
busy  out  1  high in RUN

Behaviour:
- Reset (rst=1 at an edge): state IDLE, every ring = SEED, q[c] = SEED[DEPTH-1], cycle_cnt = 0, phase = 0, wrap = 0, busy = 0, load_ready = 1. Reset mid-RUN aborts immediately with the same values.
- States:
  - IDLE: load_ready=1. If load_valid, capture load_data into the rings, clear cycle_cnt and phase, and stay in IDLE. Else if run, go to RUN. Load wins over run in the same cycle.
  - RUN: load_ready=0, busy=1, load_valid ignored. Each cycle every ring updates per mode, and cycle_cnt increments, saturating at 2^CNT_W-1. When run=0 at an edge, return to IDLE without updating that edge; rings hold.
- Ring update per mode, with s = ring, D = DEPTH, all channels identical:
  - hold: s unchanged.
  - toggle: s <= ~s (every stage inverts, generalising Q→A feedback).
  - rotate: s[i] <= s[i-1], s[0] <= s[D-1]; phase (clog2(D) bits) increments modulo D.
  - LFSR: s[i] <= s[i-1], s[0] <= ^(s & TAPS). If s == 0, s[0] <= 1 (lock-up escape).
- wrap: registered. Asserted for exactly one cycle, on the edge where phase goes D-1→0 in rotate mode; 0 otherwise.
- mode changes take effect on the next RUN edge. Phase is kept across mode changes and cleared only by load or reset.
- Latency: q reflects the ring state one edge after the update; no combinational path from inputs to q, wrap or cycle_cnt.

Optional Feature:
ROUTE_RING_PARITY_EN: when defined, adds output port parity (CHANNELS wide). It is registered, parity[c] = XOR of all bits of ring c after each update, and is 0 during reset. When undefined, the port and its logic are absent and behaviour is otherwise identical.

Test Plan:
1. Reset (CHANNELS=4, DEPTH=8, SEED=8'h01), rst high 2 cycles -> q=4'b0000, cycle_cnt=0, load_ready=1, busy=0, wrap=0.
2. Load 8'h81 into all rings, mode=01, run 3 cycles -> rings 7E,81,7E; q=4'hF then 0,F,0 on successive edges; cycle_cnt=3.
3. Load ch0=8'h01 (others 0), mode=10, run 8 cycles -> q[0]=1 only after edge 7; after edge 8 ring0=8'h01 and wrap=1 for exactly one cycle.
4. Load all zeros, mode=11, run 1 cycle -> every ring=8'h01; next cycle, feedback from taps gives 8'h02.
5. CNT_W=4, mode=00, run 20 cycles -> cycle_cnt stops at 15; rings unchanged.
6. load_valid=1 and run=1 in the same IDLE cycle -> data loaded, state stays IDLE, busy=0. Raise load_valid during RUN -> ignored, load_ready=0.
